// File: rtl/mc_defs.sv
// ----------------------------------------------------------------------------
// mc_defs -- opcode, func, ALU-control, mux-select and state encodings
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mc_defs;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_addiu = 6'b001001;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;

  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_slt = 6'b101010;

  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_or  = 3'b011;
  localparam logic [2:0] c_alu_slt = 3'b100;

  localparam logic [1:0] c_srcb_reg     = 2'b00;
  localparam logic [1:0] c_srcb_four    = 2'b01;
  localparam logic [1:0] c_srcb_imm     = 2'b10;
  localparam logic [1:0] c_srcb_imm_sh2 = 2'b11;

  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  localparam logic [3:0] c_s_fetch    = 4'd0;
  localparam logic [3:0] c_s_decode   = 4'd1;
  localparam logic [3:0] c_s_exec_r   = 4'd2;
  localparam logic [3:0] c_s_r_wb     = 4'd3;
  localparam logic [3:0] c_s_exec_i   = 4'd4;
  localparam logic [3:0] c_s_i_wb     = 4'd5;
  localparam logic [3:0] c_s_mem_addr = 4'd6;
  localparam logic [3:0] c_s_mem_rd   = 4'd7;
  localparam logic [3:0] c_s_mem_wb   = 4'd8;
  localparam logic [3:0] c_s_mem_wr   = 4'd9;
  localparam logic [3:0] c_s_branch   = 4'd10;
  localparam logic [3:0] c_s_jump     = 4'd11;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_if -- datapath status in, control strobes/selects out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_if;

  logic [5:0] OP;
  logic [5:0] func;
  logic       Zero;
  logic       mem_ready;

  logic       PCWr;
  logic       IorD;
  logic       IRWr;
  logic       MemRd;
  logic       MemWr;
  logic       RegWr;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic       ExtOp;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] ALUctr;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    output OP, func, Zero, mem_ready,
    input  PCWr, IorD, IRWr, MemRd, MemWr, RegWr, RegDst, MemtoReg,
           ALUSrcA, ExtOp, ALUSrcB, PCSrc, ALUctr, instr_done, illegal_op
  );

  modport slave (
    input  OP, func, Zero, mem_ready,
    output PCWr, IorD, IRWr, MemRd, MemWr, RegWr, RegDst, MemtoReg,
           ALUSrcA, ExtOp, ALUSrcB, PCSrc, ALUctr, instr_done, illegal_op
  );

endinterface

`default_nettype wire

// File: rtl/mc_alu_decode.sv
// ----------------------------------------------------------------------------
// mc_alu_decode -- R-type func field to ALU control, flags undefined funcs
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mc_alu_decode
  import mc_defs::*;
(
  input  logic [5:0] i_func,
  output logic [2:0] o_alu_ctr,
  output logic       o_func_ok
);

  always_comb begin
    o_alu_ctr = c_alu_add;
    o_func_ok = 1'b1;
    case (i_func)
      c_fn_add: o_alu_ctr = c_alu_add;
      c_fn_sub: o_alu_ctr = c_alu_sub;
      c_fn_and: o_alu_ctr = c_alu_and;
      c_fn_or:  o_alu_ctr = c_alu_or;
      c_fn_slt: o_alu_ctr = c_alu_slt;
      default:  o_func_ok = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control -- multicycle MIPS-subset control FSM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multicycle_control
  import mc_defs::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_control_if.slave        bus
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       r_instr_done;

  logic       w_pcwr, w_iord, w_irwr, w_memrd, w_memwr, w_regwr;
  logic       w_regdst, w_memtoreg, w_alusrca, w_extop, w_ill;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [2:0] w_aluctr;
  logic [2:0] w_func_alu;
  logic       w_func_ok;

  mc_alu_decode u_alu_decode (
    .i_func    (bus.func),
    .o_alu_ctr (w_func_alu),
    .o_func_ok (w_func_ok)
  );

  always_comb begin
    w_next     = r_state;
    w_pcwr     = 1'b0;
    w_iord     = 1'b0;
    w_irwr     = 1'b0;
    w_memrd    = 1'b0;
    w_memwr    = 1'b0;
    w_regwr    = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_alusrca  = 1'b0;
    w_extop    = 1'b0;
    w_ill      = 1'b0;
    w_alusrcb  = c_srcb_reg;
    w_pcsrc    = c_pcsrc_alu;
    w_aluctr   = c_alu_add;
    case (r_state)
      c_s_fetch: begin
        w_memrd   = 1'b1;
        w_alusrcb = c_srcb_four;
        if (bus.mem_ready) begin
          w_irwr = 1'b1;
          w_pcwr = 1'b1;
          w_next = c_s_decode;
        end
      end
      c_s_decode: begin
        w_alusrcb = c_srcb_imm_sh2;
        w_extop   = 1'b1;
        case (bus.OP)
          c_op_rtype:           w_next = c_s_exec_r;
          c_op_ori, c_op_addiu: w_next = c_s_exec_i;
          c_op_lw, c_op_sw:     w_next = c_s_mem_addr;
          c_op_beq:             w_next = c_s_branch;
          c_op_j:               w_next = c_s_jump;
          default: begin
            w_ill  = 1'b1;
            w_next = c_s_fetch;
          end
        endcase
      end
      // An undefined func is dropped here so R_WB never writes the register file
      c_s_exec_r: begin
        w_alusrca = 1'b1;
        w_aluctr  = w_func_alu;
        if (w_func_ok) begin
          w_next = c_s_r_wb;
        end else begin
          w_ill  = 1'b1;
          w_next = c_s_fetch;
        end
      end
      c_s_r_wb: begin
        w_regwr  = 1'b1;
        w_regdst = 1'b1;
        w_next   = c_s_fetch;
      end
      c_s_exec_i: begin
        w_alusrca = 1'b1;
        w_alusrcb = c_srcb_imm;
        if (bus.OP == c_op_ori) begin
          w_aluctr = c_alu_or;
        end else begin
          w_extop = 1'b1;
        end
        w_next = c_s_i_wb;
      end
      c_s_i_wb: begin
        w_regwr = 1'b1;
        w_next  = c_s_fetch;
      end
      c_s_mem_addr: begin
        w_alusrca = 1'b1;
        w_alusrcb = c_srcb_imm;
        w_extop   = 1'b1;
        w_next    = (bus.OP == c_op_lw) ? c_s_mem_rd : c_s_mem_wr;
      end
      c_s_mem_rd: begin
        w_memrd = 1'b1;
        w_iord  = 1'b1;
        if (bus.mem_ready) w_next = c_s_mem_wb;
      end
      c_s_mem_wb: begin
        w_regwr    = 1'b1;
        w_memtoreg = 1'b1;
        w_next     = c_s_fetch;
      end
      c_s_mem_wr: begin
        w_memwr = 1'b1;
        w_iord  = 1'b1;
        if (bus.mem_ready) w_next = c_s_fetch;
      end
      c_s_branch: begin
        w_alusrca = 1'b1;
        w_aluctr  = c_alu_sub;
        w_pcsrc   = c_pcsrc_aluout;
        w_pcwr    = bus.Zero;
        w_next    = c_s_fetch;
      end
      c_s_jump: begin
        w_pcsrc = c_pcsrc_jump;
        w_pcwr  = 1'b1;
        w_next  = c_s_fetch;
      end
      default: w_next = c_s_fetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_s_fetch;
      r_instr_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_instr_done <= (r_state != c_s_fetch) && (w_next == c_s_fetch) && !w_ill;
    end
  end

  // Strobes are gated by rst_n so they fall the instant reset asserts
  assign bus.PCWr       = w_pcwr  & rst_n;
  assign bus.IRWr       = w_irwr  & rst_n;
  assign bus.MemRd      = w_memrd & rst_n;
  assign bus.MemWr      = w_memwr & rst_n;
  assign bus.RegWr      = w_regwr & rst_n;
  assign bus.IorD       = w_iord;
  assign bus.RegDst     = w_regdst;
  assign bus.MemtoReg   = w_memtoreg;
  assign bus.ALUSrcA    = w_alusrca;
  assign bus.ExtOp      = w_extop;
  assign bus.ALUSrcB    = w_alusrcb;
  assign bus.PCSrc      = w_pcsrc;
  assign bus.ALUctr     = w_aluctr;
  assign bus.instr_done = r_instr_done;
  assign bus.illegal_op = w_ill & rst_n;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control -- scoreboard bench for the multicycle control FSM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Word layout: PCWr IorD IRWr MemRd MemWr RegWr RegDst MemtoReg ALUSrcA ExtOp
  //              ALUSrcB[1:0] PCSrc[1:0] ALUctr[2:0] instr_done illegal_op
  localparam logic [18:0] c_pcwr    = 19'd1 << 18;
  localparam logic [18:0] c_iord    = 19'd1 << 17;
  localparam logic [18:0] c_irwr    = 19'd1 << 16;
  localparam logic [18:0] c_memrd   = 19'd1 << 15;
  localparam logic [18:0] c_memwr   = 19'd1 << 14;
  localparam logic [18:0] c_regwr   = 19'd1 << 13;
  localparam logic [18:0] c_regdst  = 19'd1 << 12;
  localparam logic [18:0] c_m2r     = 19'd1 << 11;
  localparam logic [18:0] c_srca    = 19'd1 << 10;
  localparam logic [18:0] c_ext     = 19'd1 << 9;
  localparam logic [18:0] c_srcb4   = 19'd1 << 7;
  localparam logic [18:0] c_srcbimm = 19'd2 << 7;
  localparam logic [18:0] c_srcbsh2 = 19'd3 << 7;
  localparam logic [18:0] c_pcs_out = 19'd1 << 5;
  localparam logic [18:0] c_pcs_j   = 19'd2 << 5;
  localparam logic [18:0] c_sub     = 19'd1 << 2;
  localparam logic [18:0] c_and     = 19'd2 << 2;
  localparam logic [18:0] c_or      = 19'd3 << 2;
  localparam logic [18:0] c_slt     = 19'd4 << 2;
  localparam logic [18:0] c_done    = 19'd2;
  localparam logic [18:0] c_ill     = 19'd1;

  localparam logic [18:0] c_e_rst   = c_srcb4;
  localparam logic [18:0] c_e_fwait = c_memrd | c_srcb4;
  localparam logic [18:0] c_e_fgo   = c_e_fwait | c_pcwr | c_irwr;
  localparam logic [18:0] c_e_dec   = c_srcbsh2 | c_ext;
  localparam logic [18:0] c_e_exr   = c_srca;
  localparam logic [18:0] c_e_rwb   = c_regwr | c_regdst;
  localparam logic [18:0] c_e_ori   = c_srca | c_srcbimm | c_or;
  localparam logic [18:0] c_e_addiu = c_srca | c_srcbimm | c_ext;
  localparam logic [18:0] c_e_iwb   = c_regwr;
  localparam logic [18:0] c_e_ma    = c_srca | c_srcbimm | c_ext;
  localparam logic [18:0] c_e_mrd   = c_memrd | c_iord;
  localparam logic [18:0] c_e_mwb   = c_regwr | c_m2r;
  localparam logic [18:0] c_e_mwr   = c_memwr | c_iord;
  localparam logic [18:0] c_e_br    = c_srca | c_sub | c_pcs_out;
  localparam logic [18:0] c_e_jmp   = c_pcs_j | c_pcwr;

  logic [18:0] q_exp[$];
  string       q_tag[$];
  int          n_tests;
  int          n_fail;
  logic [5:0]  cur_op;
  logic [5:0]  cur_fn;
  logic        pend_done;
  logic        idle_rdy;

  logic [18:0] m_exp;
  logic [18:0] m_act;
  string       m_tag;

  initial begin
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        m_exp = q_exp.pop_front();
        m_tag = q_tag.pop_front();
        m_act = {bus.PCWr, bus.IorD, bus.IRWr, bus.MemRd, bus.MemWr, bus.RegWr,
                 bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ExtOp, bus.ALUSrcB,
                 bus.PCSrc, bus.ALUctr, bus.instr_done, bus.illegal_op};
        n_tests++;
        if (m_act !== m_exp) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b", m_tag, m_act, m_exp);
        end
      end
    end
  end

  task automatic cyc(input logic z, input logic rdy, input logic rn,
                     input logic [18:0] e, input string tag);
    @(posedge clk);
    #1;
    bus.OP        = cur_op;
    bus.func      = cur_fn;
    bus.Zero      = z;
    bus.mem_ready = rdy;
    rst_n         = rn;
    q_exp.push_back(e);
    q_tag.push_back(tag);
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++)
      cyc(1'b0, 1'b0, 1'b1, c_e_fwait | ((pend_done && i == 0) ? c_done : 19'd0), "fetch_wait");
    cyc(1'b0, 1'b1, 1'b1, c_e_fgo | ((pend_done && waits == 0) ? c_done : 19'd0), "fetch_go");
    pend_done = 1'b0;
  endtask

  task automatic run_r(input logic [5:0] fn, input logic [18:0] alu, input int w);
    cur_op = 6'b000000; cur_fn = fn; idle_rdy = ~idle_rdy;
    fetch(w);
    cyc(idle_rdy, idle_rdy, 1'b1, c_e_dec, "r_decode");
    cyc(idle_rdy, idle_rdy, 1'b1, c_e_exr | alu, "r_exec");
    cyc(idle_rdy, idle_rdy, 1'b1, c_e_rwb, "r_wb");
    pend_done = 1'b1;
  endtask

  task automatic run_i(input logic [5:0] op, input logic [18:0] ex);
    cur_op = op; cur_fn = 6'b000000; idle_rdy = ~idle_rdy;
    fetch(0);
    cyc(idle_rdy, idle_rdy, 1'b1, c_e_dec, "i_decode");
    cyc(idle_rdy, idle_rdy, 1'b1, ex, "i_exec");
    cyc(idle_rdy, idle_rdy, 1'b1, c_e_iwb, "i_wb");
    pend_done = 1'b1;
  endtask

  task automatic run_mem(input logic is_lw, input int w);
    cur_op = is_lw ? 6'b100011 : 6'b101011; idle_rdy = ~idle_rdy;
    fetch(0);
    cyc(idle_rdy, idle_rdy, 1'b1, c_e_dec, "mem_decode");
    cyc(idle_rdy, idle_rdy, 1'b1, c_e_ma, "mem_addr");
    for (int i = 0; i < w; i++)
      cyc(idle_rdy, 1'b0, 1'b1, is_lw ? c_e_mrd : c_e_mwr, "mem_wait");
    cyc(idle_rdy, 1'b1, 1'b1, is_lw ? c_e_mrd : c_e_mwr, "mem_go");
    if (is_lw) cyc(idle_rdy, idle_rdy, 1'b1, c_e_mwb, "lw_wb");
    pend_done = 1'b1;
  endtask

  task automatic run_beq(input logic z);
    cur_op = 6'b000100; idle_rdy = ~idle_rdy;
    fetch(0);
    cyc(~z, idle_rdy, 1'b1, c_e_dec, "beq_decode");
    cyc(z, idle_rdy, 1'b1, c_e_br | (z ? c_pcwr : 19'd0), "beq_branch");
    pend_done = 1'b1;
  endtask

  task automatic run_j();
    cur_op = 6'b000010; idle_rdy = ~idle_rdy;
    fetch(0);
    cyc(idle_rdy, idle_rdy, 1'b1, c_e_dec, "j_decode");
    cyc(idle_rdy, idle_rdy, 1'b1, c_e_jmp, "j_jump");
    pend_done = 1'b1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    cur_op = 6'b0; cur_fn = 6'b0; pend_done = 1'b0; idle_rdy = 1'b0;
    bus.OP = 6'b0; bus.func = 6'b0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;

    cyc(1'b0, 1'b0, 1'b0, c_e_rst, "reset");
    cyc(1'b1, 1'b1, 1'b0, c_e_rst, "reset_rdy");

    run_r(6'b100000, 19'd0, 3);
    run_r(6'b100010, c_sub, 0);
    run_r(6'b100100, c_and, 0);
    run_r(6'b100101, c_or, 1);
    run_r(6'b101010, c_slt, 0);
    run_i(6'b001101, c_e_ori);
    run_i(6'b001001, c_e_addiu);
    run_mem(1'b1, 2);
    run_mem(1'b1, 0);
    run_mem(1'b0, 1);
    run_beq(1'b1);
    run_beq(1'b0);
    run_j();

    // Undefined opcode: flagged in DECODE, no retire pulse on return
    cur_op = 6'b111111;
    fetch(0);
    cyc(1'b1, 1'b1, 1'b1, c_e_dec | c_ill, "illegal_op");
    pend_done = 1'b0;

    // Undefined func: flagged in EXEC_R, never reaches write-back
    cur_op = 6'b000000; cur_fn = 6'b111111;
    fetch(0);
    cyc(1'b0, 1'b0, 1'b1, c_e_dec, "badfn_decode");
    cyc(1'b0, 1'b0, 1'b1, c_e_exr | c_ill, "badfn_exec");
    pend_done = 1'b0;

    run_r(6'b100000, 19'd0, 0);

    // Reset asserted while MEM_WR waits on mem_ready
    cur_op = 6'b101011;
    fetch(0);
    cyc(1'b0, 1'b0, 1'b1, c_e_dec, "sw_decode");
    cyc(1'b0, 1'b0, 1'b1, c_e_ma, "sw_addr");
    cyc(1'b0, 1'b0, 1'b1, c_e_mwr, "sw_wait");
    cyc(1'b0, 1'b0, 1'b0, c_e_rst, "rst_in_memwr");
    cyc(1'b0, 1'b1, 1'b0, c_e_rst, "rst_hold");
    pend_done = 1'b0;
    run_j();
    cyc(1'b0, 1'b0, 1'b1, c_e_fwait | c_done, "final_done");

    for (int i = 0; i < 20 && q_exp.size() > 0; i++) @(posedge clk);
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
